// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode-classification helpers for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    // Function-select field (ctrl[1:0]) inherited from the 1-bit slice ALU.
    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_ADD = 2'b10;
    localparam logic [1:0] FN_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] ctrl);
        return ctrl == OP_MUL;
    endfunction

    function automatic logic is_legal_op(input logic [3:0] ctrl);
        logic legal;
        case (ctrl)
            OP_AND, OP_OR, OP_ADD, OP_SUB,
            OP_SLT, OP_NOR, OP_MUL: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational WIDTH-bit ALU core: operand inversion, AND/OR, add/sub and
// set-less-than, with carry-out and signed-overflow flags.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             carry_into_msb;
    logic             ovf_raw;

    assign a_eff = ctrl_i[3] ? ~a_i : a_i;
    assign b_eff = ctrl_i[2] ? ~b_i : b_i;
    // Inverting B always comes with carry-in 1, turning the adder into A - B.
    assign cin   = ctrl_i[2];

    assign sum            = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign carry_into_msb = sum[WIDTH-1] ^ a_eff[WIDTH-1] ^ b_eff[WIDTH-1];
    assign ovf_raw        = carry_into_msb ^ sum[WIDTH];

    always_comb begin
        result_o   = '0;
        cout_o     = 1'b0;
        overflow_o = 1'b0;
        case (ctrl_i[1:0])
            FN_AND: result_o = a_eff & b_eff;
            FN_OR:  result_o = a_eff | b_eff;
            FN_ADD: begin
                result_o   = sum[WIDTH-1:0];
                cout_o     = sum[WIDTH];
                overflow_o = ovf_raw;
            end
            FN_SLT: begin
                result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
                cout_o   = sum[WIDTH];
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered flags and a multi-cycle
// shift-add unsigned multiplier.
//
//  state | meaning
//  IDLE  | ready for a new operation
//  MUL   | shift-add multiply in progress, one multiplier bit per cycle
//  DONE  | result and flags held until the consumer accepts them
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = $clog2(WIDTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [WIDTH-1:0]  result_hi_o,
    output logic              zero_o,
    output logic              cout_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               zero_q;
    logic               cout_q;
    logic               overflow_q;
    logic               illegal_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [3:0]         op;
    logic               ctrl_hi_zero;
    logic               op_legal;
    logic               op_mul;
    logic [WIDTH-1:0]   core_result;
    logic               core_cout;
    logic               core_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_d;

    assign op = ctrl_i[3:0];

    if (CTRL_W > 4) begin : g_ctrl_hi
        assign ctrl_hi_zero = ~|ctrl_i[CTRL_W-1:4];
    end else begin : g_ctrl_narrow
        assign ctrl_hi_zero = 1'b1;
    end

    assign op_legal = ctrl_hi_zero & is_legal_op(op);
    assign op_mul   = ctrl_hi_zero & is_mul_op(op);

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i        (src1_i),
        .b_i        (src2_i),
        .ctrl_i     (op),
        .result_o   (core_result),
        .cout_o     (core_cout),
        .overflow_o (core_ovf)
    );

    // acc_q = {partial product, unconsumed multiplier bits}; its LSB is the
    // multiplier bit of the current step and product bits fill in from the top.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        in_ready_q <= 1'b0;
                        if (op_mul) begin
                            mcand_q <= src1_i;
                            acc_q   <= {{WIDTH{1'b0}}, src2_i};
                            cnt_q   <= '0;
                            state_q <= MUL;
                        end else begin
                            result_q    <= op_legal ? core_result : '0;
                            result_hi_q <= '0;
                            zero_q      <= op_legal ? (core_result == '0) : 1'b1;
                            cout_q      <= op_legal & core_cout;
                            overflow_q  <= op_legal & core_ovf;
                            illegal_q   <= ~op_legal;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q    <= acc_d[WIDTH-1:0];
                        result_hi_q <= acc_d[2*WIDTH-1:WIDTH];
                        zero_q      <= (acc_d == '0);
                        cout_q      <= 1'b0;
                        overflow_q  <= 1'b0;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign zero_o      = zero_q;
    assign cout_o      = cout_q;
    assign overflow_o  = overflow_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases, then random operations
// checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  src1_i;
    logic [W-1:0]  src2_i;
    logic [3:0]    ctrl_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  result_o;
    logic [W-1:0]  result_hi_o;
    logic          zero_o;
    logic          cout_o;
    logic          overflow_o;
    logic          illegal_o;

    alu_seq #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .ctrl_i      (ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .result_hi_o (result_hi_o),
        .zero_o      (zero_o),
        .cout_o      (cout_o),
        .overflow_o  (overflow_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
        logic         ill;
        logic         mul;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic force_rdy = 1'b1;
    logic rdy_val = 1'b1;
    logic seen = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] c);
        exp_t e;
        logic [63:0] prod;
        e.r = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.mul = 1'b0;
        e.acc_cyc = 0;
        case (c)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                {e.c, e.r} = {1'b0, a} + {1'b0, b};
                e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'b0110: begin
                e.r = a - b;
                e.c = (a >= b);
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'b0111: begin
                e.r = ($signed(a) < $signed(b)) ? 1 : 0;
                e.c = (a >= b);
            end
            4'b1100: e.r = ~(a | b);
            4'b1000: begin
                prod = 64'(a) * 64'(b);
                e.r = prod[W-1:0];
                e.hi = prod[63:W];
                e.mul = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.r == '0) && (e.hi == '0);
        return e;
    endfunction

    // Consumer: random backpressure unless the stimulus pins out_ready_i.
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            out_ready_i = force_rdy ? rdy_val : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pop on the first cycle a result is presented, then check it stays put.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                seen = 1'b0;
            end else if (out_valid_o) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got result %0h with no operation pending", result_o);
                    end else begin
                        cur = sb.pop_front();
                        chk("result",    64'(result_o),    64'(cur.r));
                        chk("result_hi", 64'(result_hi_o), 64'(cur.hi));
                        chk("zero",      64'(zero_o),      64'(cur.z));
                        chk("cout",      64'(cout_o),      64'(cur.c));
                        chk("overflow",  64'(overflow_o),  64'(cur.v));
                        chk("illegal",   64'(illegal_o),   64'(cur.ill));
                        chk("latency",   64'(cyc - cur.acc_cyc + 1), cur.mul ? 64'(W + 1) : 64'd1);
                    end
                    seen = 1'b1;
                end else begin
                    chk("hold_result", 64'(result_o), 64'(cur.r));
                end
                if (out_ready_i) seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(posedge clk_i);
        #1;
        src1_i = a; src2_i = b; ctrl_i = c; in_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("issue_timeout", 64'd0, 64'd1);
            in_valid_i = 1'b0;
            return;
        end
        e = model(a, b, c);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        // Scramble inputs right after acceptance; the DUT must ignore them.
        src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && !out_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit stray;
        rst_i = 1'b1;
        in_valid_i = 1'b1;
        src1_i = 32'd3; src2_i = 32'd4; ctrl_i = 4'b0010;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_out_valid", 64'(out_valid_o), 64'd0);
        chk("reset_in_ready",  64'(in_ready_o),  64'd1);
        chk("reset_result",    64'(result_o),    64'd0);
        chk("reset_result_hi", 64'(result_hi_o), 64'd0);
        chk("reset_flags",     64'({zero_o, cout_o, overflow_o, illegal_o}), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (out_valid_o) stray = 1'b1;
        end
        chk("no_result_after_reset", 64'(stray), 64'd0);

        force_rdy = 1'b0;
        issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
        issue(32'd5,         32'd5,         4'b0110);
        issue(32'hFFFF_FFFF, 32'd1,         4'b0111);
        issue(32'd0,         32'd0,         4'b1100);
        issue(32'h1234_5678, 32'hABCD_0000, 4'b0101);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000);
        issue(32'h8000_0000, 32'h0000_0001, 4'b0110);
        drain();

        // Backpressure: result must be held and new requests ignored.
        force_rdy = 1'b1;
        rdy_val = 1'b0;
        issue(32'd3, 32'd4, 4'b0010);
        src1_i = 32'd9; src2_i = 32'd9; ctrl_i = 4'b0010; in_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("bp_out_valid", 64'(out_valid_o), 64'd1);
            chk("bp_in_ready",  64'(in_ready_o),  64'd0);
            chk("bp_result",    64'(result_o),    64'd7);
        end
        in_valid_i = 1'b0;
        rdy_val = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("bp_release_in_ready",  64'(in_ready_o),  64'd1);
        chk("bp_release_out_valid", 64'(out_valid_o), 64'd0);

        // Reset part-way through a multiply: nothing may come out.
        issue(32'hDEAD_BEEF, 32'h0000_1234, 4'b1000);
        repeat (8) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        stray = 1'b0;
        repeat (W + 8) begin
            @(negedge clk_i);
            if (out_valid_o) stray = 1'b1;
        end
        chk("abort_no_valid", 64'(stray),      64'd0);
        chk("abort_in_ready", 64'(in_ready_o), 64'd1);

        force_rdy = 1'b0;
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = b;
            issue(a, b, 4'($urandom_range(0, 15)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
